// File: rtl/count_checker.sv
// count_checker: watches an upstream modulo counter for illegal steps and
// queues a lap number in a small FWFT FIFO each time the counter wraps.
module count_checker #(
    parameter int MAX_COUNT = 10,
    parameter int LAP_W     = 8,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count_in,
    input  logic             count_vld,
    output logic [LAP_W-1:0] lap_data,
    output logic             lap_valid,
    input  logic             lap_ready,
    output logic             seq_err,
    output logic             ovf,
    input  logic             err_clr,
    output logic [LAP_W-1:0] lap_total
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] MAX = 4'(MAX_COUNT);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [LAP_W-1:0] lap_total_q, lap_total_d, lap_inc;
    logic [LAP_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             seq_err_q, seq_err_d, ovf_q, ovf_d;
    logic             legal, wrap, bad, full, pop, push;

    always_comb begin
        legal       = (prev_q < MAX && {1'b0, count_in} == {1'b0, prev_q} + 5'd1) ||
                      (count_in == 4'd0 && (prev_q == MAX || prev_q == 4'd0));
        wrap        = count_vld && state_q == TRACK && prev_q == MAX && count_in == 4'd0;
        bad         = count_vld && state_q == TRACK && !legal;
        full        = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        pop         = lap_valid && lap_ready;
        push        = wrap && (!full || pop);
        lap_inc     = lap_total_q + LAP_W'(1);
        lap_total_d = wrap ? lap_inc : lap_total_q;
        state_d     = !count_vld ? state_q :
                      state_q == SYNC ? (count_in == 4'd0 ? TRACK : SYNC) :
                      (legal ? TRACK : SYNC);
        prev_d      = (count_vld && (state_q == SYNC ? count_in == 4'd0 : legal)) ? count_in : prev_q;
        // A new error event on the same edge as err_clr leaves the flag set.
        seq_err_d   = bad || (seq_err_q && !err_clr);
        ovf_d       = (wrap && full && !pop) || (ovf_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SYNC;
            prev_q      <= '0;
            lap_total_q <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            seq_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            lap_total_q <= lap_total_d;
            seq_err_q   <= seq_err_d;
            ovf_q       <= ovf_d;
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= lap_inc;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    assign lap_valid = wr_q != rd_q;
    assign lap_data  = lap_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign lap_total = lap_total_q;
    assign seq_err   = seq_err_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed checks of lap counting, sequence errors,
// FIFO overflow/drain and asynchronous reset for count_checker.
module tb_count_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count_in = '0;
    logic       count_vld = 1'b0;
    logic [7:0] lap_data;
    logic       lap_valid;
    logic       lap_ready = 1'b0;
    logic       seq_err, ovf;
    logic       err_clr = 1'b0;
    logic [7:0] lap_total;
    int n_cmp = 0;
    int n_err = 0;

    count_checker dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
        .lap_data(lap_data), .lap_valid(lap_valid), .lap_ready(lap_ready),
        .seq_err(seq_err), .ovf(ovf), .err_clr(err_clr), .lap_total(lap_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] v);
        count_in  = v;
        count_vld = 1'b1;
        step();
        count_vld = 1'b0;
    endtask

    task automatic lap();
        for (int v = 1; v <= 10; v++) sample(4'(v));
        sample(4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        @(negedge clk) rst = 1'b1;
        step();
    endtask

    initial begin
        // reset state while rst held low
        #2;
        chk("rst_valid", 32'(lap_valid), 0);
        chk("rst_data", 32'(lap_data), 0);
        chk("rst_total", 32'(lap_total), 0);
        chk("rst_seq", 32'(seq_err), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(negedge clk) rst = 1'b1;
        step();

        // one clean lap
        lap_ready = 1'b1;
        sample(4'd0);
        lap();
        chk("lap1_total", 32'(lap_total), 1);
        chk("lap1_valid", 32'(lap_valid), 1);
        chk("lap1_data", 32'(lap_data), 1);
        chk("lap1_seq", 32'(seq_err), 0);
        step();
        chk("lap1_popped", 32'(lap_valid), 0);

        // sequence error then resync
        do_reset();
        sample(4'd0); sample(4'd1); sample(4'd2); sample(4'd5);
        chk("seq_at5", 32'(seq_err), 1);
        sample(4'd3);
        sample(4'd0);
        lap();
        chk("seq_total", 32'(lap_total), 1);
        chk("seq_sticky", 32'(seq_err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("seq_clr", 32'(seq_err), 0);
        count_in  = 4'd4;
        count_vld = 1'b1;
        err_clr   = 1'b1;
        step();
        count_vld = 1'b0;
        err_clr   = 1'b0;
        chk("seq_set_wins", 32'(seq_err), 1);

        // overflow with stalled consumer, then in-order drain
        do_reset();
        lap_ready = 1'b0;
        sample(4'd0);
        for (int i = 0; i < 4; i++) lap();
        chk("ovf_4laps", 32'(ovf), 0);
        chk("ovf_head_hold", 32'(lap_data), 1);
        lap();
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_total", 32'(lap_total), 5);
        lap_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), 32'(lap_data), 32'(i));
            step();
        end
        chk("drain_empty", 32'(lap_valid), 0);
        chk("ovf_after_drain", 32'(ovf), 1);

        // full FIFO with pop on the wrap edge
        do_reset();
        lap_ready = 1'b0;
        sample(4'd0);
        for (int i = 0; i < 4; i++) lap();
        for (int v = 1; v <= 10; v++) sample(4'(v));
        lap_ready = 1'b1;
        sample(4'd0);
        lap_ready = 1'b0;
        chk("fullpop_ovf", 32'(ovf), 0);
        chk("fullpop_total", 32'(lap_total), 5);
        chk("fullpop_head", 32'(lap_data), 2);
        lap_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("fullpop_drain_%0d", i), 32'(lap_data), 32'(i));
            step();
        end
        chk("fullpop_empty", 32'(lap_valid), 0);

        // gapped valid, then out-of-range value
        do_reset();
        lap_ready = 1'b0;
        sample(4'd0);
        for (int v = 1; v <= 11; v++) begin
            count_in = 4'd7;
            step();
            sample(v == 11 ? 4'd0 : 4'(v));
        end
        chk("gap_total", 32'(lap_total), 1);
        chk("gap_data", 32'(lap_data), 1);
        chk("gap_seq", 32'(seq_err), 0);
        sample(4'd11);
        chk("gap_ovr11", 32'(seq_err), 1);

        // asynchronous reset mid-lap with queued records
        do_reset();
        lap_ready = 1'b0;
        sample(4'd0);
        lap();
        lap();
        chk("ar_valid_pre", 32'(lap_valid), 1);
        for (int v = 1; v <= 5; v++) sample(4'(v));
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(lap_valid), 0);
        chk("ar_total", 32'(lap_total), 0);
        chk("ar_data", 32'(lap_data), 0);
        @(negedge clk) rst = 1'b1;
        step();
        sample(4'd6);
        chk("ar_sync_noflag", 32'(seq_err), 0);
        sample(4'd0);
        lap();
        chk("ar_relap_total", 32'(lap_total), 1);
        chk("ar_relap_data", 32'(lap_data), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
